// File: rtl/change_dispenser_if.sv
// change_dispenser_if: payout request and coin-solenoid status bundle between
// the change controller (master) and the change dispenser (slave).
interface change_dispenser_if;
  logic       start;
  logic [7:0] amount;
  logic       busy;
  logic       done;
  logic       coin_out1;
  logic       coin_out2;
  logic       coin_out5;
  logic       coin_strobe;
  logic [7:0] coin_value;
  logic [7:0] remaining;
  logic [7:0] coins_dispensed;
  modport master (
    output start, amount,
    input  busy, done, coin_out1, coin_out2, coin_out5, coin_strobe,
    input  coin_value, remaining, coins_dispensed
  );
  modport slave (
    input  start, amount,
    output busy, done, coin_out1, coin_out2, coin_out5, coin_strobe,
    output coin_value, remaining, coins_dispensed
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: pays out an amount greedily as 5/2/1 coins, one fixed-width
// solenoid pulse plus idle gap per coin.
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input logic clk,
  input logic rst,
  change_dispenser_if.slave bus
);
  localparam int MAXC = PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES;
  localparam int W = $clog2(MAXC + 1);
  localparam logic [W-1:0] P_LD = W'(PULSE_CYCLES - 1);
  localparam logic [W-1:0] G_LD = W'(GAP_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;
  state_t       state;
  logic [W-1:0] cnt;
  logic [7:0]   remaining, coin_value, coins_dispensed, coin;
  logic         busy, done, coin_strobe;
  always_comb coin = remaining >= 8'd5 ? 8'd5 : remaining >= 8'd2 ? 8'd2 : 8'd1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      remaining       <= '0;
      coin_value      <= '0;
      coins_dispensed <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      coin_strobe     <= 1'b0;
    end else begin
      coin_strobe <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          remaining       <= bus.amount;
          coins_dispensed <= '0;
          state           <= bus.amount != 8'd0 ? SELECT : DONE;
          busy            <= bus.amount != 8'd0;
          done            <= bus.amount == 8'd0;
        end
        SELECT: begin
          coin_value      <= coin;
          remaining       <= remaining - coin;
          coins_dispensed <= coins_dispensed + 8'd1;
          coin_strobe     <= 1'b1;
          cnt             <= P_LD;
          state           <= PULSE;
        end
        PULSE: if (cnt == '0) begin
          cnt   <= G_LD;
          state <= GAP;
        end else cnt <= cnt - 1'b1;
        GAP: if (cnt != '0) cnt <= cnt - 1'b1;
        else if (remaining != 8'd0) state <= SELECT;
        else begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // Solenoids decode only registered state, so async reset drops them at once.
  assign bus.coin_out1       = state == PULSE && coin_value == 8'd1;
  assign bus.coin_out2       = state == PULSE && coin_value == 8'd2;
  assign bus.coin_out5       = state == PULSE && coin_value == 8'd5;
  assign bus.busy            = busy;
  assign bus.done            = done;
  assign bus.coin_strobe     = coin_strobe;
  assign bus.coin_value      = coin_value;
  assign bus.remaining       = remaining;
  assign bus.coins_dispensed = coins_dispensed;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized and directed payouts checked against a
// cycle-timing model derived from the greedy coin count formula.
module tb_change_dispenser;
  localparam int P = 4, G = 4, T = 1 + P + G;
  logic clk = 1'b0, rst = 1'b0;
  int errors = 0, checks = 0;
  change_dispenser_if bus();
  change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct packed {logic c5, c2, c1, s, d, b; logic [7:0] rem, cnt;} st_t;
  st_t        tr[$];
  logic [7:0] vq[$];

  function automatic st_t obs();
    return {bus.coin_out5, bus.coin_out2, bus.coin_out1, bus.coin_strobe, bus.done, bus.busy,
            bus.remaining, bus.coins_dispensed};
  endfunction

  function automatic logic [29:0] outs();
    return {bus.busy, bus.done, bus.coin_out1, bus.coin_out2, bus.coin_out5, bus.coin_strobe,
            bus.coin_value, bus.remaining, bus.coins_dispensed};
  endfunction

  function automatic int ncoins(int a);
    return a / 5 + (a % 5) / 2 + (a % 5) % 2;
  endfunction

  // value paid after the first n greedy coins
  function automatic int paid(int a, int n);
    int k5 = a / 5, k2 = (a % 5) / 2;
    return n <= k5 ? 5 * n : n <= k5 + k2 ? 5 * k5 + 2 * (n - k5) : 5 * k5 + 2 * k2 + 1;
  endfunction

  // expected observation in cycle c after acceptance (cycle 1 = first cycle after the edge)
  function automatic st_t model(int a, int c);
    int k = ncoins(a), i = (c - 1) / T, off = (c - 1) % T, coin, n;
    st_t e = '0;
    coin = paid(a, i + 1) - paid(a, i);
    if (c == 1 + k * T) begin
      e.d = 1'b1;
      e.cnt = 8'(k);
    end else if (c < 1 + k * T) begin
      n = off == 0 ? i : i + 1;
      e.b = 1'b1;
      e.rem = 8'(a - paid(a, n));
      e.cnt = 8'(n);
      e.s = off == 1;
      e.c5 = off >= 1 && off <= P && coin == 5;
      e.c2 = off >= 1 && off <= P && coin == 2;
      e.c1 = off >= 1 && off <= P && coin == 1;
    end
    return e;
  endfunction

  task automatic run(input int a, input int maxc);
    tr.delete();
    vq.delete();
    tr.push_back('0);
    vq.push_back('0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.amount = 8'(a);
    @(negedge clk);
    bus.start = 1'b0;
    bus.amount = 8'($urandom);
    for (int c = 1; c <= maxc; c++) begin
      if (c > 1) @(negedge clk);
      tr.push_back(obs());
      vq.push_back(bus.coin_value);
      if (bus.done) break;
    end
  endtask

  function automatic int done_cycle();
    return tr[$].d ? tr.size() - 1 : -1;
  endfunction

  task automatic test_reset();
    int act = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.amount = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs());
    end
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (outs() !== '0) act++;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL reset_idle: %0d active cycles, expected 0", act);
    end
  endtask

  task automatic test_amount8();
    int mism = 0, pbad = 0, dc;
    logic [23:0] got = '0;
    int ns = 0;
    run(8, 60);
    dc = done_cycle();
    foreach (tr[c]) if (c > 0) begin
      if (tr[c] !== model(8, c)) mism++;
      if (tr[c].s) begin
        got = {got[15:0], vq[c]};
        ns++;
      end
      if (tr[c].c5 !== (c >= 2 && c <= 5) || tr[c].c2 !== (c >= 11 && c <= 14) ||
          tr[c].c1 !== (c >= 20 && c <= 23)) pbad++;
    end
    checks++;
    if (ns != 3 || got !== 24'h050201) begin
      errors++;
      $display("FAIL amt8_order: got %0d coins %h expected 3 coins 050201", ns, got);
    end
    checks++;
    if (pbad != 0) begin
      errors++;
      $display("FAIL amt8_pulses: %0d cycles with wrong coin outputs, expected 0", pbad);
    end
    checks++;
    if (dc != 28) begin
      errors++;
      $display("FAIL amt8_done: got cycle %0d expected 28", dc);
    end
    checks++;
    if ({tr[$].rem, tr[$].cnt} !== {8'd0, 8'd3}) begin
      errors++;
      $display("FAIL amt8_final: got rem=%0d coins=%0d expected rem=0 coins=3", tr[$].rem, tr[$].cnt);
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL amt8_trace: %0d cycles differ from model", mism);
    end
  endtask

  task automatic test_zero();
    int act = 0, dc;
    run(0, 5);
    dc = done_cycle();
    checks++;
    if (dc != 1 || tr[1] !== model(0, 1)) begin
      errors++;
      $display("FAIL zero_done: got cycle %0d obs %h expected cycle 1 obs %h", dc, tr[1], model(0, 1));
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.busy || bus.coin_strobe || bus.coin_out1 || bus.coin_out2 || bus.coin_out5) act++;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL zero_quiet: %0d active cycles after done, expected 0", act);
    end
  endtask

  task automatic test_max();
    int ns = 0, bad = 0, multi = 0, mism = 0, dc;
    run(255, 600);
    dc = done_cycle();
    foreach (tr[c]) if (c > 0) begin
      if (tr[c].s) begin
        ns++;
        if (!tr[c].c5 || vq[c] != 8'd5) bad++;
      end
      if (int'(tr[c].c5) + int'(tr[c].c2) + int'(tr[c].c1) > 1) multi++;
      if (tr[c] !== model(255, c)) mism++;
    end
    checks++;
    if (ns != 51 || bad != 0) begin
      errors++;
      $display("FAIL max_strobes: got %0d strobes (%0d not 5-coin) expected 51 (0)", ns, bad);
    end
    checks++;
    if (multi != 0) begin
      errors++;
      $display("FAIL max_exclusive: %0d cycles with several coin outputs, expected 0", multi);
    end
    checks++;
    if (dc != 1 + 51 * T) begin
      errors++;
      $display("FAIL max_done: got cycle %0d expected %0d", dc, 1 + 51 * T);
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL max_trace: %0d cycles differ from model", mism);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      int a = r == 0 ? 1 : r == 1 ? 4 : int'($urandom_range(0, 60));
      int k = ncoins(a), mism = 0, first = -1, dc;
      run(a, 1 + k * T + 5);
      dc = done_cycle();
      foreach (tr[c]) if (c > 0 && tr[c] !== model(a, c)) begin
        mism++;
        if (first < 0) first = c;
      end
      checks++;
      if (mism != 0) begin
        errors++;
        $display("FAIL rand_trace: amount %0d, %0d cycles differ, first cycle %0d got %h expected %h",
                 a, mism, first, tr[first], model(a, first));
      end
      checks++;
      if (dc != 1 + k * T) begin
        errors++;
        $display("FAIL rand_done: amount %0d got cycle %0d expected %0d", a, dc, 1 + k * T);
      end
      checks++;
      if (tr[$].cnt !== 8'(k)) begin
        errors++;
        $display("FAIL rand_count: amount %0d got %0d coins expected %0d", a, tr[$].cnt, k);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ns = 0, dc = -1, cnt_at_done = -1;
    logic [23:0] got = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.amount = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.coin_strobe) begin
        got = {got[15:0], bus.coin_value};
        ns++;
      end
      if (bus.done) begin
        dc = c;
        cnt_at_done = int'(bus.coins_dispensed);
      end
      if (c == 5) begin
        bus.start = 1'b1;
        bus.amount = 8'd3;
      end
    end
    checks++;
    if (ns != 2 || got !== 24'h000502 || cnt_at_done != 2) begin
      errors++;
      $display("FAIL mid_start_ignored: got %0d coins %h count %0d expected 2 coins 000502 count 2",
               ns, got, cnt_at_done);
    end
    checks++;
    if (dc != 1 + 2 * T) begin
      errors++;
      $display("FAIL mid_start_done: got cycle %0d expected %0d", dc, 1 + 2 * T);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL held_start_idle: got busy %b expected 0", bus.busy);
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.remaining, bus.coins_dispensed} !== {1'b1, 8'd3, 8'd0}) begin
      errors++;
      $display("FAIL held_start_accept: got busy=%b rem=%0d coins=%0d expected busy=1 rem=3 coins=0",
               bus.busy, bus.remaining, bus.coins_dispensed);
    end
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.coin_strobe, bus.coin_out2, bus.coin_value, bus.remaining} !== {1'b1, 1'b1, 8'd2, 8'd1}) begin
      errors++;
      $display("FAIL held_start_coin: got strobe=%b out2=%b value=%0d rem=%0d expected 1 1 2 1",
               bus.coin_strobe, bus.coin_out2, bus.coin_value, bus.remaining);
    end
    dc = -1;
    for (int c = 0; c < 40 && dc < 0; c++) begin
      @(negedge clk);
      if (bus.done) dc = c;
    end
    checks++;
    if (dc < 0) begin
      errors++;
      $display("FAIL held_start_finish: no done within 40 cycles, expected one");
    end
  endtask

  task automatic test_reset_mid();
    int act = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.amount = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.coin_out5 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got coin_out5 %b expected 1", bus.coin_out5);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL rst_mid_drop: got %h expected 0 without a clock edge", outs());
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (outs() !== '0) act++;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL rst_mid_after: %0d active cycles after release, expected 0", act);
    end
  endtask

  initial begin
    test_reset();
    test_amount8();
    test_zero();
    test_max();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
